elevator_dispatch_queue: RTL and testbench
==========================================

// Module: elevator_dispatch_queue
// PURPOSE
// Request side of the driver interface: collects floor calls for one cab, picks the next destination,
// and drives go/en/des into the driver controller. It also takes the driver's newSt/on feedback.
// When the cab arrives it clears the call and holds a door dwell before the next trip.
// There is one instance per elevator (two in the twin-elevator top).
// PARAMETERS
// DOOR_TICKS  4  number of tick_2s strobes the door stays open after arrival (4 = 2 s)
// PORTS
// clk        in   1  system clock
// reset      in   1  synchronous, active-high reset
// tick_2s    in   1  one-clk strobe at 2 Hz, aligned with the driver's step instant
// req_valid  in   1  call request strobe (button press, already debounced)
// req_floor  in   4  requested floor, one-hot (0001=F0 .. 1000=F3)
// cState     in   4  current cab floor, one-hot (driver newSt fed back)
// moving     in   1  driver "on" feedback
// go         out  1  trip request to the driver
// en         out  1  driver enable; 0 while the door is open or a fault is set
// des        out  4  destination, one-hot; 4'b1111 = none
// pending    out  4  outstanding calls bitmap (bit i = floor i)
// dir_up     out  1  current sweep direction
// door_open  out  1  door dwell in progress
// arrived    out  1  one-clk pulse when a destination is reached
// req_err    out  1  one-clk pulse when req_floor is not one-hot
// fault      out  1  sticky; set when cState is not one-hot, cleared only by reset
// BEHAVIOUR
// - Reset values: state=IDLE, pending=0, go=0, en=1, des=4'b1111, dir_up=1, door_open=0, arrived=0,
//   req_err=0, fault=0, dwell count=0. A reset mid-trip aborts the trip at once; go=0 stops the driver
//   at its next tick.
// - Request capture: req_valid with a one-hot req_floor sets the matching pending bit on the next clk edge.
//   A duplicate request has no effect. A zero or multi-hot req_floor is dropped and pulses req_err.
// - Request for the current floor: if the cab is stopped (IDLE or DOOR), go to DOOR and restart the dwell.
//   The bit is not left set in pending. During TRAVEL it is stored like any other request.
// - FSM states: IDLE, SELECT, TRAVEL, DOOR. State and all outputs are registered.
//   - IDLE: des=1111, go=0. Move to SELECT on the clk after pending becomes non-zero.
//   - SELECT (1 clk): sweep policy.
//     - dir_up=1: nearest pending floor above cState. If there is none, nearest below, and set dir_up=0.
//     - dir_up=0: the mirror of the above.
//     - Latch the chosen floor into des. Go to TRAVEL.
//   - TRAVEL: go=1, en=1.
//     - Checked every clk: if cState==des, then go=0, clear pending[des], pulse arrived, go to DOOR, dwell=0.
//     - Retarget: a pending floor strictly between cState and des, in dir_up direction, replaces des.
//       des never changes on a clk where tick_2s=1 (the driver samples then); a retarget is deferred one clk.
//   - DOOR: door_open=1, en=0, go=0.
//     - Count tick_2s. At DOOR_TICKS, go to SELECT if pending!=0, else to IDLE.
//     - A call for the current floor during DOOR restarts the count.
// - Simultaneous events:
//   - A request captured on the arrival clk for the same floor is absorbed (bit stays 0).
//   - A request for another floor on the same clk is kept.
// - Comparison: an unsigned compare of one-hot vectors gives floor order. Any non-one-hot cState
//   sets fault, forces go=0, en=0, and jumps to IDLE. pending is retained.
// - Latency: request to go=1 is 2 clk from IDLE (capture, SELECT).
// STRUCTURE
// - Shared package elevator_pkg:
//   - floor_t (logic [3:0])
//   - FLOOR_NONE = 4'b1111
//   - disp_state_t enum {IDLE, SELECT, TRAVEL, DOOR}
//   - function is_onehot(floor_t)
//   - function nearest_above/below(pending, cur)
// - One sub-module, dispatch_target_picker: combinational. Inputs pending, cState, dir_up.
//   Outputs next_des, next_dir, found. It is reused for SELECT and for the retarget check.
// - Dwell counter and FSM stay in the top module.
// TESTING
// 1. Reset; cState=0001; req F3 (1000).
//    -> 2 clk later des=1000, go=1, dir_up=1. When cState=1000: arrived pulse, pending=0000,
//    door_open=1 for 4 ticks, then IDLE with des=1111.
// 2. Cab at F0 heading to F3; req F1 (0010) while cState=0001 and tick_2s=0.
//    -> des becomes 0010 next clk. On a tick_2s clk the des update is deferred by 1 clk.
// 3. Cab at F2 going up, pending={F3,F0}.
//    -> F3 served first, then SELECT sets dir_up=0 and des=0001.
// 4. req_floor=0110 -> req_err pulse, pending unchanged. req_floor=cState while in DOOR -> dwell restarts from 0.
// 5. Assert reset mid-TRAVEL (go=1, des=1000) -> next clk go=0, des=1111, pending=0, state IDLE.
// 6. Force cState=0011 during TRAVEL -> fault=1, go=0, en=0. fault stays set until reset.

Source files
------------

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared floor types, dispatcher states and one-hot floor helpers
package elevator_pkg;

  typedef logic [3:0] floor_t;

  localparam floor_t FLOOR_NONE = 4'b1111;

  typedef enum logic [1:0] {IDLE, SELECT, TRAVEL, DOOR} disp_state_t;

  function automatic logic is_onehot(input floor_t f);
    return (f != '0) && ((f & (f - 4'd1)) == '0);
  endfunction

  // Lowest pending floor strictly above cur; 0 when there is none.
  function automatic floor_t nearest_above(input floor_t pending, input floor_t cur);
    floor_t res;
    logic   seen;
    res  = '0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (seen && pending[i] && (res == '0)) res = floor_t'(1) << i;
      if (cur[i]) seen = 1'b1;
    end
    return res;
  endfunction

  function automatic floor_t nearest_below(input floor_t pending, input floor_t cur);
    floor_t res;
    logic   seen;
    res  = '0;
    seen = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (seen && pending[i] && (res == '0)) res = floor_t'(1) << i;
      if (cur[i]) seen = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dispatch_target_picker.sv
// rtl/dispatch_target_picker.sv - sweep-policy choice of the next destination floor
module dispatch_target_picker
  import elevator_pkg::*;
(
  input  floor_t pending,
  input  floor_t cState,
  input  logic   dir_up,
  output floor_t next_des,
  output logic   next_dir,
  output logic   found
);

  floor_t above;
  floor_t below;

  assign above = nearest_above(pending, cState);
  assign below = nearest_below(pending, cState);

  // Keep sweeping in the current direction; reverse only when nothing lies ahead.
  always_comb begin
    next_des = FLOOR_NONE;
    next_dir = dir_up;
    found    = 1'b0;
    if (dir_up) begin
      if (above != '0) begin
        next_des = above;
        next_dir = 1'b1;
        found    = 1'b1;
      end else if (below != '0) begin
        next_des = below;
        next_dir = 1'b0;
        found    = 1'b1;
      end
    end else begin
      if (below != '0) begin
        next_des = below;
        next_dir = 1'b0;
        found    = 1'b1;
      end else if (above != '0) begin
        next_des = above;
        next_dir = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_dispatch_queue.sv
// rtl/elevator_dispatch_queue.sv - per-cab call queue, sweep dispatcher and door dwell
module elevator_dispatch_queue
  import elevator_pkg::*;
#(
  parameter int DOOR_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_2s,
  input  logic       req_valid,
  input  logic [3:0] req_floor,
  input  logic [3:0] cState,
  input  logic       moving,
  output logic       go,
  output logic       en,
  output logic [3:0] des,
  output logic [3:0] pending,
  output logic       dir_up,
  output logic       door_open,
  output logic       arrived,
  output logic       req_err,
  output logic       fault
);

  localparam int DW = $clog2(DOOR_TICKS + 1);

  disp_state_t state_q, state_d;
  floor_t      pending_q, pending_d, des_q, des_d;
  logic        go_q, go_d, en_q, en_d, dir_up_q, dir_up_d, door_q, door_d;
  logic        arrived_q, arrived_d, req_err_q, req_err_d, fault_q, fault_d;
  logic [DW-1:0] dwell_q, dwell_d;

  logic   req_ok, cur_req, retarget;
  floor_t pending_set, pick_des;
  logic   pick_dir, pick_found;

  // Arrival is judged from cState alone; the motion flag is informational.
  logic unused_moving;
  assign unused_moving = moving;

  assign req_ok      = req_valid && is_onehot(req_floor);
  assign cur_req     = req_ok && (req_floor == cState);
  assign pending_set = pending_q | (req_ok ? req_floor : '0);

  dispatch_target_picker u_picker (
    .pending  (pending_set),
    .cState   (cState),
    .dir_up   (dir_up_q),
    .next_des (pick_des),
    .next_dir (pick_dir),
    .found    (pick_found)
  );

  assign retarget = pick_found && (pick_dir == dir_up_q) &&
                    (dir_up_q ? (pick_des < des_q) : (pick_des > des_q));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_set;
    des_d     = des_q;
    dir_up_d  = dir_up_q;
    dwell_d   = dwell_q;
    arrived_d = 1'b0;
    req_err_d = req_valid && !is_onehot(req_floor);
    fault_d   = fault_q || !is_onehot(cState);
    if (fault_d) begin
      state_d = IDLE;
      dwell_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cur_req) begin
            pending_d = pending_set & ~cState;
            state_d   = DOOR;
            dwell_d   = '0;
          end else if (pending_set != '0) begin
            state_d = SELECT;
          end
        end
        SELECT: begin
          if ((pending_set & cState) != '0) begin
            pending_d = pending_set & ~cState;
            state_d   = DOOR;
            dwell_d   = '0;
          end else if (pick_found) begin
            des_d    = pick_des;
            dir_up_d = pick_dir;
            state_d  = TRAVEL;
          end else begin
            state_d = IDLE;
          end
        end
        TRAVEL: begin
          if (cState == des_q) begin
            pending_d = pending_set & ~des_q;
            arrived_d = 1'b1;
            state_d   = DOOR;
            dwell_d   = '0;
          end else if (!tick_2s && retarget) begin
            // The driver samples des on tick clocks, so retargets wait for a quiet clock.
            des_d = pick_des;
          end
        end
        DOOR: begin
          if (cur_req) begin
            pending_d = pending_set & ~cState;
            dwell_d   = '0;
          end else if (tick_2s) begin
            if (dwell_q == DW'(DOOR_TICKS - 1)) begin
              dwell_d = '0;
              state_d = (pending_set != '0) ? SELECT : IDLE;
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    go_d   = (state_d == TRAVEL);
    door_d = (state_d == DOOR);
    en_d   = !door_d && !fault_d;
    if (state_d != TRAVEL) des_d = FLOOR_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      go_q      <= 1'b0;
      en_q      <= 1'b1;
      des_q     <= FLOOR_NONE;
      dir_up_q  <= 1'b1;
      door_q    <= 1'b0;
      arrived_q <= 1'b0;
      req_err_q <= 1'b0;
      fault_q   <= 1'b0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      go_q      <= go_d;
      en_q      <= en_d;
      des_q     <= des_d;
      dir_up_q  <= dir_up_d;
      door_q    <= door_d;
      arrived_q <= arrived_d;
      req_err_q <= req_err_d;
      fault_q   <= fault_d;
      dwell_q   <= dwell_d;
    end
  end

  assign go        = go_q;
  assign en        = en_q;
  assign des       = des_q;
  assign pending   = pending_q;
  assign dir_up    = dir_up_q;
  assign door_open = door_q;
  assign arrived   = arrived_q;
  assign req_err   = req_err_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_elevator_dispatch_queue.sv
// tb/tb_elevator_dispatch_queue.sv - randomized self-checking bench with an integer-floor reference model
module tb_elevator_dispatch_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_2s = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_floor = 4'b0000;
  logic [3:0] cState = 4'b0001;
  logic       moving = 1'b0;
  logic       go, en, dir_up, door_open, arrived, req_err, fault;
  logic [3:0] des, pending;

  always #5 clk = ~clk;

  elevator_dispatch_queue #(.DOOR_TICKS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_2s   (tick_2s),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .cState    (cState),
    .moving    (moving),
    .go        (go),
    .en        (en),
    .des       (des),
    .pending   (pending),
    .dir_up    (dir_up),
    .door_open (door_open),
    .arrived   (arrived),
    .req_err   (req_err),
    .fault     (fault)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: floors as integers 0..3, pending as a bitmap indexed by floor.
  localparam int S_IDLE = 0, S_SEL = 1, S_TRV = 2, S_DOOR = 3;
  int       m_st = S_IDLE, m_des = -1, m_dwell = 0;
  bit [3:0] m_pend = '0;
  bit       m_dir = 1'b1, m_fault = 1'b0, m_arr = 1'b0, m_err = 1'b0;

  int       cab = 0;
  bit       force_cs = 1'b0;
  logic [3:0] force_val = 4'b0000;

  function automatic int floor_idx(input logic [3:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input bit rst, input bit tk, input bit rv,
                            input logic [3:0] rf, input logic [3:0] cs);
    int cur, ri, t;
    bit [3:0] np;
    if (rst) begin
      m_st = S_IDLE; m_pend = '0; m_des = -1; m_dir = 1'b1; m_dwell = 0;
      m_fault = 1'b0; m_arr = 1'b0; m_err = 1'b0;
      return;
    end
    cur   = floor_idx(cs);
    ri    = rv ? floor_idx(rf) : -1;
    m_err = rv && (ri < 0);
    m_arr = 1'b0;
    np    = m_pend;
    if (ri >= 0) np[ri] = 1'b1;
    if (m_fault || cur < 0) begin
      m_fault = 1'b1; m_st = S_IDLE; m_dwell = 0;
    end else begin
      case (m_st)
        S_IDLE: begin
          if (ri == cur) begin np[cur] = 1'b0; m_st = S_DOOR; m_dwell = 0; end
          else if (np != 0) m_st = S_SEL;
        end
        S_SEL: begin
          if (np[cur]) begin
            np[cur] = 1'b0; m_st = S_DOOR; m_dwell = 0;
          end else begin
            t = -1;
            if (m_dir) begin
              for (int f = cur + 1; f < 4; f++) if (np[f] && t < 0) t = f;
              if (t < 0) begin
                for (int f = cur - 1; f >= 0; f--) if (np[f] && t < 0) t = f;
                if (t >= 0) m_dir = 1'b0;
              end
            end else begin
              for (int f = cur - 1; f >= 0; f--) if (np[f] && t < 0) t = f;
              if (t < 0) begin
                for (int f = cur + 1; f < 4; f++) if (np[f] && t < 0) t = f;
                if (t >= 0) m_dir = 1'b1;
              end
            end
            if (t >= 0) begin m_des = t; m_st = S_TRV; end
            else m_st = S_IDLE;
          end
        end
        S_TRV: begin
          if (cur == m_des) begin
            np[cur] = 1'b0; m_arr = 1'b1; m_st = S_DOOR; m_dwell = 0;
          end else if (!tk) begin
            t = -1;
            if (m_dir) begin
              for (int f = cur + 1; f < m_des; f++) if (np[f] && t < 0) t = f;
            end else begin
              for (int f = cur - 1; f > m_des; f--) if (np[f] && t < 0) t = f;
            end
            if (t >= 0) m_des = t;
          end
        end
        default: begin
          if (ri == cur) begin np[cur] = 1'b0; m_dwell = 0; end
          else if (tk) begin
            m_dwell++;
            if (m_dwell == 4) begin m_dwell = 0; m_st = (np != 0) ? S_SEL : S_IDLE; end
          end
        end
      endcase
    end
    m_pend = np;
  endtask

  task automatic cycle();
    bit pre_go;
    int pre_des;
    pre_go  = (m_st == S_TRV);
    pre_des = m_des;
    @(posedge clk);
    model_step(reset, tick_2s, req_valid, req_floor, cState);
    if (!reset && tick_2s && pre_go && cab != pre_des) cab += (pre_des > cab) ? 1 : -1;
    #1;
    check_eq("go", go, m_st == S_TRV);
    check_eq("en", en, (m_st != S_DOOR) && !m_fault);
    check_eq("des", des, (m_st == S_TRV) ? 4'(1 << m_des) : 4'hF);
    check_eq("pending", pending, m_pend);
    check_eq("dir_up", dir_up, m_dir);
    check_eq("door_open", door_open, m_st == S_DOOR);
    check_eq("arrived", arrived, m_arr);
    check_eq("req_err", req_err, m_err);
    check_eq("fault", fault, m_fault);
    cState = force_cs ? force_val : 4'(1 << cab);
    moving = (m_st == S_TRV);
  endtask

  task automatic idle(input int n, input int tick_every);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      tick_2s   = (tick_every > 0) && (i % tick_every == tick_every - 1);
      cycle();
    end
    tick_2s = 1'b0;
  endtask

  task automatic press(input logic [3:0] f, input bit tk);
    req_valid = 1'b1; req_floor = f; tick_2s = tk;
    cycle();
    req_valid = 1'b0; tick_2s = 1'b0;
  endtask

  task automatic do_reset(input int at_floor);
    reset = 1'b1; cab = at_floor; force_cs = 1'b0; cState = 4'(1 << cab);
    req_valid = 1'b0; tick_2s = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  task automatic run_until_arrive(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      req_valid = 1'b0; tick_2s = (i % 4 == 3);
      cycle();
      if (arrived) seen = 1'b1;
    end
    tick_2s = 1'b0;
    check_eq(tag, seen, 1);
  endtask

  task automatic count_door_ticks(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      req_valid = 1'b0; tick_2s = (i % 3 == 2);
      cycle();
      if (tick_2s) n++;
      if (!door_open) break;
    end
    tick_2s = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;

    // Basic trip F0 -> F3 with latency, arrival and dwell.
    do_reset(0);
    check_eq("rst_des", des, 4'hF);
    check_eq("rst_en", en, 1);
    check_eq("rst_go", go, 0);
    check_eq("rst_dir", dir_up, 1);
    press(4'b1000, 1'b0);
    idle(1, 0);
    check_eq("t1_go", go, 1);
    check_eq("t1_des", des, 4'b1000);
    run_until_arrive("t1_arrive");
    check_eq("t1_pend", pending, 0);
    check_eq("t1_door", door_open, 1);
    count_door_ticks(n);
    check_eq("t1_dwell", n, 4);
    check_eq("t1_idle_des", des, 4'hF);

    // Retarget to an intermediate floor, immediate and tick-deferred.
    do_reset(0);
    press(4'b1000, 1'b0);
    idle(1, 0);
    press(4'b0010, 1'b0);
    check_eq("t2_retarget", des, 4'b0010);
    idle(120, 4);
    do_reset(0);
    press(4'b1000, 1'b0);
    idle(1, 0);
    press(4'b0100, 1'b1);
    check_eq("t2_defer_hold", des, 4'b1000);
    idle(1, 0);
    check_eq("t2_defer_apply", des, 4'b0100);
    idle(120, 4);

    // Sweep reversal: at F2 going up with F3 and F0 pending.
    do_reset(2);
    press(4'b1000, 1'b0);
    press(4'b0001, 1'b0);
    check_eq("t3_first", des, 4'b1000);
    run_until_arrive("t3_arr1");
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick_2s = (i % 4 == 3); cycle();
      if (go) seen = 1'b1;
    end
    tick_2s = 1'b0;
    check_eq("t3_go2", seen, 1);
    check_eq("t3_des2", des, 4'b0001);
    check_eq("t3_dir2", dir_up, 0);
    run_until_arrive("t3_arr2");
    idle(40, 4);

    // Malformed request, then a current-floor call restarting the dwell.
    press(4'b0110, 1'b0);
    check_eq("t4_err", req_err, 1);
    idle(1, 0);
    check_eq("t4_err_clr", req_err, 0);
    press(4'(1 << cab), 1'b0);
    check_eq("t4_door", door_open, 1);
    idle(2, 1);
    press(4'(1 << cab), 1'b0);
    count_door_ticks(n);
    check_eq("t4_restart", n, 4);

    // Reset mid-trip.
    do_reset(0);
    press(4'b1000, 1'b0);
    idle(1, 0);
    check_eq("t5_go_before", go, 1);
    reset = 1'b1; cycle(); reset = 1'b0;
    check_eq("t5_go", go, 0);
    check_eq("t5_des", des, 4'hF);
    check_eq("t5_pend", pending, 0);

    // Malformed cab position during travel.
    do_reset(0);
    press(4'b1000, 1'b0);
    idle(1, 0);
    force_cs = 1'b1; force_val = 4'b0011; cState = 4'b0011;
    idle(1, 0);
    check_eq("t6_fault", fault, 1);
    check_eq("t6_go", go, 0);
    check_eq("t6_en", en, 0);
    force_cs = 1'b0;
    press(4'b0100, 1'b0);
    idle(6, 2);
    check_eq("t6_sticky", fault, 1);
    do_reset(0);
    check_eq("t6_cleared", fault, 0);

    // Randomized traffic against the model.
    do_reset($urandom_range(0, 3));
    for (int i = 0; i < 4000; i++) begin
      tick_2s   = ($urandom_range(0, 3) == 0);
      req_valid = ($urandom_range(0, 4) == 0);
      req_floor = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'(1 << $urandom_range(0, 3));
      reset     = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
